// File: rtl/key_direction_ctrl_pkg.sv
// Shared game definitions: direction encoding, key bit positions and the
// request arbitration/legality helpers used by the direction controller.
package key_direction_ctrl_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int NUM_KEYS  = 4;
    localparam int KEY_UP    = 3;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_RIGHT = 0;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } req_t;

    // Fixed priority up > down > left > right; lower-priority presses are dropped.
    function automatic req_t pick_request(input logic [NUM_KEYS-1:0] p);
        req_t r;
        r.valid = |p;
        if (p[KEY_UP]) begin
            r.dir = DIR_UP;
        end else if (p[KEY_DOWN]) begin
            r.dir = DIR_DOWN;
        end else if (p[KEY_LEFT]) begin
            r.dir = DIR_LEFT;
        end else begin
            r.dir = DIR_RIGHT;
        end
        return r;
    endfunction

    // Opposite directions differ only in bit 0, so a reversal is ref_dir ^ 1.
    function automatic logic is_blocked(input logic [1:0] req_dir, input logic [1:0] ref_dir);
        return (req_dir == ref_dir) || (req_dir == (ref_dir ^ 2'd1));
    endfunction

endpackage

// File: rtl/key_direction_ctrl_key_debounce.sv
// Single pushbutton conditioner: 2-flop synchronizer (active-high after
// inversion), saturating-free debounce counter, debounced level and press pulse.
module key_debounce
    import key_direction_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_state,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          state_d, state_q;
    logic          press_d, press_q;

    // Counter clears on agreement and at terminal count, so it can never wrap.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (sync2_q == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            state_d = ~state_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        press_d = state_d & ~state_q;
    end

    // Synchronizer, debounce state and press pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= ~key_n;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            press_q <= press_d;
        end
    end

    assign key_state = state_q;
    assign press     = press_q;

endmodule

// File: rtl/key_direction_ctrl.sv
// Snake direction controller: debounces four keys, filters illegal turns,
// holds one pending turn and commits it on each game step.
module key_direction_ctrl
    import key_direction_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    input  logic       step,
    input  logic       restart,
    output logic [1:0] dir,
    output logic       dir_changed,
    output logic [3:0] press,
    output logic [3:0] key_state
);

    logic [NUM_KEYS-1:0] press_s;
    logic [NUM_KEYS-1:0] key_state_s;
    req_t                req_s;

    dir_t dir_d, dir_q;
    dir_t pend_d, pend_q;
    logic pend_valid_d, pend_valid_q;
    logic changed_d, changed_q;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk      (CLOCK_50),
            .rst_n    (rst_n),
            .key_n    (key_n[i]),
            .key_state(key_state_s[i]),
            .press    (press_s[i])
        );
    end

    // Commit first, then judge the new request against the post-commit direction.
    always_comb begin
        dir_d        = dir_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        changed_d    = 1'b0;
        req_s        = pick_request(press_s);
        if (restart) begin
            dir_d        = DIR_RIGHT;
            pend_valid_d = 1'b0;
        end else begin
            if (step && pend_valid_q) begin
                dir_d        = pend_q;
                pend_valid_d = 1'b0;
                changed_d    = (pend_q != dir_q);
            end else begin
                dir_d = dir_q;
            end
            if (req_s.valid && !is_blocked(req_s.dir, dir_d)) begin
                pend_d       = req_s.dir;
                pend_valid_d = 1'b1;
            end else begin
                pend_d = pend_q;
            end
        end
    end

    // Direction, pending request and change-pulse registers.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            dir_q        <= DIR_RIGHT;
            pend_q       <= DIR_UP;
            pend_valid_q <= 1'b0;
            changed_q    <= 1'b0;
        end else begin
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            changed_q    <= changed_d;
        end
    end

    assign dir         = dir_q;
    assign dir_changed = changed_q;
    assign press       = press_s;
    assign key_state   = key_state_s;

endmodule

// File: tb/tb_key_direction_ctrl.sv
// Directed, table-driven bench for key_direction_ctrl with DEBOUNCE_CYCLES=4.
module tb_key_direction_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n    = 1'b0;
    logic [3:0] key_n    = 4'hF;
    logic       step     = 1'b0;
    logic       restart  = 1'b0;
    logic [1:0] dir;
    logic       dir_changed;
    logic [3:0] press;
    logic [3:0] key_state;

    int n_cmp;
    int n_bad;
    int press_cnt [4];
    int chg_cnt;
    int p0 [4];
    int c0;
    int first_c;
    int pulses;

    typedef struct {
        string      name;
        logic [3:0] keys;
        logic [1:0] exp_dir;
        int         exp_chg;
    } vec_t;

    vec_t tbl [9];

    key_direction_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .step       (step),
        .restart    (restart),
        .dir        (dir),
        .dir_changed(dir_changed),
        .press      (press),
        .key_state  (key_state)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Pulse counters sampled on the inactive edge.
    always @(negedge CLOCK_50) begin
        for (int i = 0; i < 4; i++) press_cnt[i] <= press_cnt[i] + int'(press[i]);
        chg_cnt <= chg_cnt + int'(dir_changed);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic tap(input logic [3:0] mask);
        key_n = ~mask;
        cyc(8);
        key_n = 4'hF;
        cyc(8);
    endtask

    task automatic do_step();
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(1);
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) p0[i] = press_cnt[i];
        c0 = chg_cnt;
    endtask

    function automatic int press_mask();
        int m = 0;
        for (int i = 0; i < 4; i++) if (press_cnt[i] - p0[i] == 1) m |= (1 << i);
        return m;
    endfunction

    initial begin
        tbl[0] = '{"idle_step",     4'b0000, 2'd3, 0};
        tbl[1] = '{"left_rev",      4'b0010, 2'd3, 0};
        tbl[2] = '{"up_turn",       4'b1000, 2'd0, 1};
        tbl[3] = '{"up_same",       4'b1000, 2'd0, 0};
        tbl[4] = '{"down_rev",      4'b0100, 2'd0, 0};
        tbl[5] = '{"right_turn",    4'b0001, 2'd3, 1};
        tbl[6] = '{"up_left_prio",  4'b1010, 2'd0, 1};
        tbl[7] = '{"left_right_pr", 4'b0011, 2'd2, 1};
        tbl[8] = '{"idle_after",    4'b0000, 2'd2, 0};

        // Reset state
        cyc(3);
        check("rst_dir", int'(dir), 3);
        check("rst_changed", int'(dir_changed), 0);
        check("rst_press", int'(press), 0);
        check("rst_key_state", int'(key_state), 0);
        rst_n = 1'b1;
        cyc(2);

        // No keys, 20 steps
        snap();
        for (int s = 0; s < 20; s++) begin
            do_step();
            check("idle_dir", int'(dir), 3);
        end
        check("idle_changed_cnt", chg_cnt - c0, 0);
        check("idle_press_mask", press_mask(), 0);

        // Glitch on up key, then a real hold
        snap();
        key_n = 4'b0111;
        cyc(2);
        key_n = 4'hF;
        first_c = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc(1);
            if (key_state != 4'b0000) first_c = c;
        end
        check("glitch_key_state", first_c, 0);
        check("glitch_press", press_cnt[3] - p0[3], 0);

        snap();
        key_n = 4'b0111;
        first_c = 0;
        pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc(1);
            if (press[3]) begin
                pulses++;
                if (first_c == 0) first_c = c;
            end
        end
        check("press_latency", first_c, 6);
        check("press_pulses", pulses, 1);
        check("held_key_state", int'(key_state), 8);
        key_n = 4'hF;
        cyc(8);
        check("released_key_state", int'(key_state), 0);
        check("release_no_press", press_cnt[3] - p0[3], 1);
        do_step();
        check("glitch_then_up_dir", int'(dir), 0);
        check("glitch_then_up_chg", chg_cnt - c0, 1);

        // Restart returns to RIGHT
        restart = 1'b1;
        cyc(2);
        check("restart_dir", int'(dir), 3);
        check("restart_changed", int'(dir_changed), 0);
        restart = 1'b0;
        cyc(1);

        // Key held through restart makes no second press
        snap();
        key_n = 4'b0111;
        cyc(8);
        restart = 1'b1;
        cyc(3);
        restart = 1'b0;
        cyc(10);
        check("hold_restart_press", press_cnt[3] - p0[3], 1);
        check("hold_restart_key", int'(key_state), 8);
        do_step();
        check("hold_restart_dir", int'(dir), 3);
        check("hold_restart_chg", chg_cnt - c0, 0);
        key_n = 4'hF;
        cyc(8);

        // Table of single tap + step
        for (int v = 0; v < 9; v++) begin
            snap();
            tap(tbl[v].keys);
            do_step();
            check({tbl[v].name, "_dir"}, int'(dir), int'(tbl[v].exp_dir));
            check({tbl[v].name, "_chg"}, chg_cnt - c0, tbl[v].exp_chg);
            check({tbl[v].name, "_press"}, press_mask(), int'(tbl[v].keys));
        end

        // Latest accepted request wins
        snap();
        tap(4'b1000);
        tap(4'b0100);
        do_step();
        check("latest_wins_dir", int'(dir), 1);
        check("latest_wins_chg", chg_cnt - c0, 1);

        // Press coincident with step is judged against the new direction
        tap(4'b0010);
        do_step();
        check("to_left_dir", int'(dir), 2);
        tap(4'b1000);
        key_n = 4'b1101;
        cyc(6);
        check("coinc_press_vis", int'(press), 2);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        check("coinc_commit_dir", int'(dir), 0);
        cyc(1);
        key_n = 4'hF;
        cyc(8);
        do_step();
        check("coinc_next_dir", int'(dir), 2);

        // Reset mid-debounce with a pending request
        tap(4'b1000);
        key_n = 4'b1011;
        cyc(3);
        rst_n = 1'b0;
        #1;
        check("async_rst_dir", int'(dir), 3);
        check("async_rst_key", int'(key_state), 0);
        cyc(2);
        rst_n = 1'b1;
        snap();
        first_c = 0;
        pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            step = (c == 3);
            cyc(1);
            if (press[2]) begin
                pulses++;
                if (first_c == 0) first_c = c;
            end
        end
        step = 1'b0;
        check("post_rst_latency", first_c, 6);
        check("post_rst_pulses", pulses, 1);
        check("post_rst_dir", int'(dir), 3);
        check("post_rst_chg", chg_cnt - c0, 0);
        key_n = 4'hF;
        cyc(8);
        do_step();
        check("post_rst_down_dir", int'(dir), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
